spike_pushback_buffer: RTL and testbench
========================================

# spike_pushback_buffer

Buffered, parametrised spike pushback stage for the tinyODIN core. It captures each output spike (neuron address plus current tick) into a synchronous FIFO and presents it to the downstream consumer over a valid/ready handshake. It counts spikes per inference and raises a sticky `inference_done_o` on a selectable condition: last tick, spike-count threshold, or either. It sits between the neuron update pipeline and the host-side readout, replacing the combinational pass-through pushback.

## Interface
Parameters:
- `N`, 256: neuron count; address width `AW = $clog2(N)`.
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `TICK_W`, 8: tick counter width.
- `CNT_W`, 16: spike counter width.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset; one clock; reset is synchronous and active-low.
- `start_i` input 1: begin new inference; clears counter, done, and overflow.
- `spike_i` input 1: spike event this cycle.
- `count_i` input AW: address of the spiking neuron.
- `tick_i` input TICK_W: current time-step.
- `last_tick_i` input TICK_W: final tick of the inference.
- `done_mode_i` input 2: 0 = TICK, 1 = COUNT, 2 = EITHER, 3 = reserved (behaves as TICK).
- `spike_thresh_i` input CNT_W: spike-count threshold for COUNT mode.
- `pb_valid_o` output 1: head entry valid.
- `pb_ready_i` input 1: consumer accepts the head entry.
- `pb_addr_o` output AW: head entry neuron address.
- `pb_tick_o` output TICK_W: head entry tick stamp.
- `level_o` output $clog2(DEPTH)+1: FIFO occupancy.
- `spike_cnt_o` output CNT_W: spikes accepted this inference.
- `overflow_o` output 1: sticky, a spike was dropped because the FIFO was full.
- `inference_done_o` output 1: sticky inference-complete flag.

## Operation
- Accepted spike: `spike_i` high with `inference_done_o` low. It pushes `{tick_i, count_i}` and increments `spike_cnt_o`, which saturates at all-ones.
- Spikes arriving while `inference_done_o` is high are ignored. They are not pushed, not counted, and do not set overflow.
- Push when full:
  - With a pop in the same cycle: the push is accepted.
  - Without a pop: the spike is dropped, `overflow_o` is set, and it is still counted in `spike_cnt_o`.
- Pop: `pb_valid_o && pb_ready_i`. A pop on an empty FIFO is impossible because valid is low.
- Done condition, evaluated each cycle on registered inputs:
  - TICK: `tick_i == last_tick_i`.
  - COUNT: next spike count ≥ `spike_thresh_i`. Next count includes a spike accepted this cycle.
  - EITHER: logical OR of the two.
- On the done condition, `inference_done_o` is set and held until `start_i` or reset.
- `start_i`:
  - Clears `spike_cnt_o`, `overflow_o` and `inference_done_o`.
  - Does not flush the FIFO; undrained entries from the previous inference remain.
  - A spike in the same cycle as `start_i` is accepted as the first spike of the new inference, so the count becomes 1.
  - The done condition is not evaluated in the `start_i` cycle.
- `spike_thresh_i == 0` in COUNT mode: done is set on the first evaluated cycle after start.
- FIFO pointers are `$clog2(DEPTH)+1` bits wide. Full/empty are derived from the MSB comparison, and wrap-around is natural.

## Timing
- Reset values (`rst_ni` low at a rising edge): `pb_valid_o`=0, `pb_addr_o`=0, `pb_tick_o`=0, `level_o`=0, `spike_cnt_o`=0, `overflow_o`=0, `inference_done_o`=0. Reset mid-transfer discards all FIFO contents.
- Push-to-visible latency is 1 cycle: a spike accepted at edge k gives `pb_valid_o` high after edge k.
- Head data is stable while `pb_valid_o && !pb_ready_i`. The next entry appears the cycle after a pop.
- `inference_done_o` rises 1 cycle after the edge where the condition is true.
- `spike_cnt_o`, `overflow_o` and `level_o` update at the same edge as the push or pop.
- Full throughput: one push and one pop per cycle, sustained.

## Structure
- Package `spike_pb_pkg` holds:
  - enum `done_mode_e` (DONE_TICK, DONE_COUNT, DONE_EITHER);
  - parametrised entry struct `{tick, addr}`, built with typed localparams in the top module;
  - the reserved-mode decode constant.
- Sub-module `spike_pb_fifo`: generic synchronous FIFO with data-width/depth parameters, push/pop, full/empty/level. It has no knowledge of spikes.
- Top module holds the spike counter, overflow and done logic.

## Test plan
- Reset then 3 spikes (addr 5, 17, 200 at ticks 1, 1, 2) with `pb_ready_i`=1:
  - Expected: three pops in order `{1,5}`, `{1,17}`, `{2,200}`; `spike_cnt_o`=3; `overflow_o`=0.
- DEPTH=16, `pb_ready_i`=0, 18 consecutive spikes:
  - Expected: `level_o`=16, `overflow_o`=1, `spike_cnt_o`=18.
  - After draining: exactly the first 16 addresses come out.
- Full FIFO with simultaneous spike and pop:
  - Expected: push accepted, `level_o` stays 16, `overflow_o` unchanged.
- COUNT mode, `spike_thresh_i`=4, spikes every cycle:
  - Expected: done high 1 cycle after the 4th spike.
  - A 5th spike is ignored: count stays 4 and nothing is pushed.
- TICK mode, `last_tick_i`=255, tick sweeps 0→255:
  - Expected: done rises the cycle after `tick_i`=255.
  - `start_i` with a simultaneous spike: done=0, `spike_cnt_o`=1, old FIFO entries still drain.
- Assert `rst_ni` low mid-stream with 7 entries queued:
  - Expected: all outputs read reset values next cycle, and `pb_valid_o`=0.

Source files
------------

// File: rtl/spike_pb_pkg.sv
// Shared types and constants for the spike pushback buffer.
// The FIFO entry struct depends on the top-level parameters, so it is declared in the top module.
package spike_pb_pkg;

  typedef enum logic [1:0] {
    DONE_TICK   = 2'd0,
    DONE_COUNT  = 2'd1,
    DONE_EITHER = 2'd2
  } done_mode_e;

  // The reserved encoding decodes the same way as DONE_TICK.
  localparam logic [1:0] DoneModeRsvd = 2'd3;

endpackage

// File: rtl/spike_pb_fifo.sv
// Generic synchronous FIFO with a power-of-two depth and extra-MSB pointers.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module spike_pb_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned PtrW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW-1:0]  level_o
);

  logic [DataW-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  // Same slot index with differing MSBs means the writer has lapped the reader.
  assign w_full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_wr    = push_i && (!w_full || pop_i);
  assign w_rd    = pop_i && !w_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PtrW'(1);
      if (w_rd) r_rptr <= r_rptr + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AddrW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rptr[AddrW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_wptr - r_rptr;

endmodule

// File: rtl/spike_pushback_buffer.sv
// Buffered spike pushback: queues {tick, addr} per output spike, counts spikes per inference
// and raises a sticky done flag on last tick, spike-count threshold, or either.
module spike_pushback_buffer
  import spike_pb_pkg::*;
#(
  parameter int unsigned N      = 256,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TICK_W = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned AW    = $clog2(N),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              spike_i,
  input  logic [AW-1:0]     count_i,
  input  logic [TICK_W-1:0] tick_i,
  input  logic [TICK_W-1:0] last_tick_i,
  input  logic [1:0]        done_mode_i,
  input  logic [CNT_W-1:0]  spike_thresh_i,
  output logic              pb_valid_o,
  input  logic              pb_ready_i,
  output logic [AW-1:0]     pb_addr_o,
  output logic [TICK_W-1:0] pb_tick_o,
  output logic [LW-1:0]     level_o,
  output logic [CNT_W-1:0]  spike_cnt_o,
  output logic              overflow_o,
  output logic              inference_done_o
);

  typedef struct packed {
    logic [TICK_W-1:0] tick;
    logic [AW-1:0]     addr;
  } pb_entry_t;

  localparam int unsigned EntryW = TICK_W + AW;

  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic [EntryW-1:0] w_rdata;
  pb_entry_t        w_wentry;
  pb_entry_t        w_head;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_done_nxt;
  logic             w_done_cond;
  logic             w_tick_hit;
  logic             w_cnt_hit;

  assign pb_valid_o = !w_empty;
  assign w_pop      = pb_valid_o && pb_ready_i;
  // start_i clears done in the same cycle, so a coincident spike belongs to the new inference.
  assign w_accept   = spike_i && (start_i || !r_done);
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;
  assign w_wentry   = '{tick: tick_i, addr: count_i};

  spike_pb_fifo #(
    .DataW (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_wentry),
    .pop_i   (w_pop),
    .data_o  (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  always_comb begin
    w_cnt_base = start_i ? '0 : r_cnt;
    w_cnt_nxt  = w_cnt_base;
    if (w_accept && (w_cnt_base != '1)) w_cnt_nxt = w_cnt_base + CNT_W'(1);
  end

  assign w_tick_hit = (tick_i == last_tick_i);
  assign w_cnt_hit  = (w_cnt_nxt >= spike_thresh_i);

  always_comb begin
    w_done_cond = w_tick_hit;
    case (done_mode_i)
      DONE_COUNT:              w_done_cond = w_cnt_hit;
      DONE_EITHER:             w_done_cond = w_tick_hit || w_cnt_hit;
      DONE_TICK, DoneModeRsvd: w_done_cond = w_tick_hit;
      default:                 w_done_cond = w_tick_hit;
    endcase
  end

  assign w_ovf_nxt  = (start_i ? 1'b0 : r_ovf) | w_drop;
  assign w_done_nxt = start_i ? 1'b0 : (r_done | w_done_cond);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= w_ovf_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Head data is masked while empty so idle and reset outputs read as zero.
  assign w_head           = pb_entry_t'(w_rdata);
  assign pb_addr_o        = pb_valid_o ? w_head.addr : '0;
  assign pb_tick_o        = pb_valid_o ? w_head.tick : '0;
  assign spike_cnt_o      = r_cnt;
  assign overflow_o       = r_ovf;
  assign inference_done_o = r_done;

endmodule

// File: tb/tb_spike_pushback_buffer.sv
// Directed self-checking bench for spike_pushback_buffer with hand-computed expectations.
module tb_spike_pushback_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        spike_i;
  logic [7:0]  count_i;
  logic [7:0]  tick_i;
  logic [7:0]  last_tick_i;
  logic [1:0]  done_mode_i;
  logic [15:0] spike_thresh_i;
  logic        pb_valid_o;
  logic        pb_ready_i;
  logic [7:0]  pb_addr_o;
  logic [7:0]  pb_tick_o;
  logic [4:0]  level_o;
  logic [15:0] spike_cnt_o;
  logic        overflow_o;
  logic        inference_done_o;

  int n_checks = 0;
  int n_errors = 0;

  spike_pushback_buffer #(
    .N      (256),
    .DEPTH  (16),
    .TICK_W (8),
    .CNT_W  (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .spike_i          (spike_i),
    .count_i          (count_i),
    .tick_i           (tick_i),
    .last_tick_i      (last_tick_i),
    .done_mode_i      (done_mode_i),
    .spike_thresh_i   (spike_thresh_i),
    .pb_valid_o       (pb_valid_o),
    .pb_ready_i       (pb_ready_i),
    .pb_addr_o        (pb_addr_o),
    .pb_tick_o        (pb_tick_o),
    .level_o          (level_o),
    .spike_cnt_o      (spike_cnt_o),
    .overflow_o       (overflow_o),
    .inference_done_o (inference_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(pb_valid_o), 0);
    check_eq({tag, "_addr"}, 32'(pb_addr_o), 0);
    check_eq({tag, "_tick"}, 32'(pb_tick_o), 0);
    check_eq({tag, "_level"}, 32'(level_o), 0);
    check_eq({tag, "_cnt"}, 32'(spike_cnt_o), 0);
    check_eq({tag, "_ovf"}, 32'(overflow_o), 0);
    check_eq({tag, "_done"}, 32'(inference_done_o), 0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; spike_i = 1'b0; count_i = '0; tick_i = '0;
    last_tick_i = 8'd255; done_mode_i = 2'd0; spike_thresh_i = 16'hffff; pb_ready_i = 1'b0;
    step(); step();
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    do_start();

    // Three spikes streamed with the consumer always ready.
    pb_ready_i = 1'b1;
    spike_i = 1'b1; count_i = 8'd5; tick_i = 8'd1;
    step();
    check_eq("s3_addr0", 32'(pb_addr_o), 5);
    check_eq("s3_tick0", 32'(pb_tick_o), 1);
    count_i = 8'd17;
    step();
    check_eq("s3_addr1", 32'(pb_addr_o), 17);
    check_eq("s3_level1", 32'(level_o), 1);
    count_i = 8'd200; tick_i = 8'd2;
    step();
    check_eq("s3_addr2", 32'(pb_addr_o), 200);
    check_eq("s3_tick2", 32'(pb_tick_o), 2);
    spike_i = 1'b0;
    step();
    check_eq("s3_valid_end", 32'(pb_valid_o), 0);
    check_eq("s3_cnt", 32'(spike_cnt_o), 3);
    check_eq("s3_ovf", 32'(overflow_o), 0);

    // Overflow: 18 spikes into a 16-entry FIFO with the consumer stalled.
    pb_ready_i = 1'b0; tick_i = 8'd3;
    do_start();
    check_eq("ovf_cnt_cleared", 32'(spike_cnt_o), 0);
    for (int i = 0; i < 18; i++) begin
      spike_i = 1'b1; count_i = 8'(i);
      step();
    end
    spike_i = 1'b0;
    check_eq("ovf_level", 32'(level_o), 16);
    check_eq("ovf_flag", 32'(overflow_o), 1);
    check_eq("ovf_cnt", 32'(spike_cnt_o), 18);

    // Full FIFO with a simultaneous spike and pop: push accepted.
    spike_i = 1'b1; count_i = 8'd99; pb_ready_i = 1'b1;
    step();
    spike_i = 1'b0;
    check_eq("full_pp_level", 32'(level_o), 16);
    check_eq("full_pp_ovf", 32'(overflow_o), 1);
    check_eq("full_pp_cnt", 32'(spike_cnt_o), 19);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'd99);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 32'(pb_valid_o), 1);
      check_eq($sformatf("drain_addr%0d", i), 32'(pb_addr_o), 32'(exp_q[i]));
      step();
    end
    check_eq("drain_empty", 32'(pb_valid_o), 0);
    exp_q.delete();

    // COUNT mode, threshold 4.
    pb_ready_i = 1'b0; done_mode_i = 2'd1; spike_thresh_i = 16'd4;
    do_start();
    check_eq("cnt_done_start", 32'(inference_done_o), 0);
    for (int i = 0; i < 4; i++) begin
      spike_i = 1'b1; count_i = 8'(40 + i);
      step();
      check_eq($sformatf("cnt_done%0d", i), 32'(inference_done_o), (i == 3) ? 1 : 0);
      check_eq($sformatf("cnt_cnt%0d", i), 32'(spike_cnt_o), 32'(i + 1));
    end
    count_i = 8'd44;
    step();
    spike_i = 1'b0;
    check_eq("cnt_5th_cnt", 32'(spike_cnt_o), 4);
    check_eq("cnt_5th_level", 32'(level_o), 4);
    check_eq("cnt_5th_done", 32'(inference_done_o), 1);

    // TICK mode, last tick 255; FIFO still holds 40..43.
    done_mode_i = 2'd0; tick_i = 8'd0;
    do_start();
    for (int t = 0; t < 256; t++) begin
      tick_i = 8'(t);
      step();
      check_eq($sformatf("tick_done_t%0d", t), 32'(inference_done_o), (t == 255) ? 1 : 0);
    end
    tick_i = 8'd0; spike_i = 1'b1; count_i = 8'd77; start_i = 1'b1;
    step();
    start_i = 1'b0; spike_i = 1'b0;
    check_eq("restart_done", 32'(inference_done_o), 0);
    check_eq("restart_cnt", 32'(spike_cnt_o), 1);
    check_eq("restart_level", 32'(level_o), 5);
    exp_q = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd77};
    pb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("old_drain%0d", i), 32'(pb_addr_o), 32'(exp_q[i]));
      step();
    end
    check_eq("old_drain_empty", 32'(pb_valid_o), 0);

    // COUNT mode with zero threshold: done on the first evaluated cycle after start.
    pb_ready_i = 1'b0; done_mode_i = 2'd1; spike_thresh_i = 16'd0;
    do_start();
    check_eq("thr0_start_cycle", 32'(inference_done_o), 0);
    step();
    check_eq("thr0_next_cycle", 32'(inference_done_o), 1);

    // Reserved mode behaves as TICK: zero threshold alone must not finish.
    done_mode_i = 2'd3;
    do_start();
    step(); step();
    check_eq("rsvd_no_done", 32'(inference_done_o), 0);
    tick_i = 8'd255;
    step();
    tick_i = 8'd0;
    check_eq("rsvd_tick_done", 32'(inference_done_o), 1);

    // Reset mid-stream with 7 entries queued.
    done_mode_i = 2'd0; spike_thresh_i = 16'hffff;
    do_start();
    for (int i = 0; i < 7; i++) begin
      spike_i = 1'b1; count_i = 8'(100 + i); tick_i = 8'(i);
      step();
    end
    spike_i = 1'b0; tick_i = 8'd0;
    check_eq("mid_level", 32'(level_o), 7);
    check_eq("mid_cnt", 32'(spike_cnt_o), 7);
    rst_ni = 1'b0;
    step();
    check_idle_outputs("midrst");
    rst_ni = 1'b1;
    step();
    check_eq("midrst_after_valid", 32'(pb_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
